bram_ring_ctrl: RTL

- Controller that runs a single-port BRAM as a ring-buffer FIFO for difftest packets in the FPGA simulation path.
- Takes a valid/ready packet stream in and gives a valid/ready stream out.
- Time-shares the one RAM port between write and read operations.
- Absorbs the RAM's 1-cycle registered read latency with a 2-entry output skid buffer, so that out_ready backpressure never loses data.

---
 rtl/bram_ring_ctrl_pkg.sv | 19 +
 rtl/bram_rd_skid.sv | 76 +++++++
 rtl/bram_ring_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bram_ring_ctrl_pkg.sv
// Shared definitions for the BRAM ring-buffer controller and its RAM wrapper.
package bram_ring_ctrl_pkg;

    // Default widths, kept in one place so the RAM wrapper and controller agree
    localparam int DEF_DATA_WIDTH = 4000;
    localparam int DEF_ADDR_WIDTH = 3;

    // Arbitration priority between the write and read side of the RAM port
    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_e;

    // Hand the priority to the other side after a contended grant
    function automatic prio_e prio_flip(input prio_e p);
        return (p == PRIO_WR) ? PRIO_RD : PRIO_WR;
    endfunction

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry skid FIFO behind the RAM read port. An incoming word falls straight
// through to the head when the FIFO is empty, so read data is visible the same
// cycle it leaves the RAM; if it is not consumed it is kept.
module bram_rd_skid
    import bram_ring_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic                  o_valid,
    output logic [1:0]            o_cnt,
    output logic [DATA_WIDTH-1:0] o_head
);

    logic [DATA_WIDTH-1:0] r_mem [0:1];
    logic                  r_wr_idx;
    logic                  r_rd_idx;
    logic [1:0]            r_cnt;

    logic w_empty;
    logic w_bypass;
    logic w_store;
    logic w_take;

    // Decide whether the incoming word is stored or passes straight through
    always_comb begin
        w_empty  = (r_cnt == 2'd0);
        w_bypass = w_empty && i_push && i_pop;
        w_store  = i_push && !w_bypass;
        w_take   = i_pop && !w_empty;
    end

    assign o_valid = !w_empty || i_push;
    assign o_head  = w_empty ? i_din : r_mem[r_rd_idx];
    assign o_cnt   = r_cnt;

    // Occupancy count and ring indices
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 2'd0;
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
        end else begin
            if (w_store) begin
                r_wr_idx <= ~r_wr_idx;
            end
            if (w_take) begin
                r_rd_idx <= ~r_rd_idx;
            end
            case ({w_store, w_take})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Payload storage; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_idx] <= i_din;
        end
    end

    // The controller only issues a read when a slot is guaranteed
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_store && !w_take && (r_cnt == 2'd2)));

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        (r_cnt != 2'd3));

endmodule

// File: rtl/bram_ring_ctrl.sv
// Runs a single-port BRAM as a ring-buffer FIFO. Writes and reads share the one
// RAM port; contended cycles alternate between the two sides. Read data arrives
// one cycle after the read and lands in a 2-entry skid FIFO, so output
// backpressure never loses a word.
module bram_ring_ctrl
    import bram_ring_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  ram_rst,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [ADDR_WIDTH:0] LP_FULL = (ADDR_WIDTH+1)'(RAM_DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_used;
    logic                  r_rd_inflight;
    prio_e                 r_prio;
    logic                  r_ram_rst;
    logic [ADDR_WIDTH+1:0] r_level;

    logic                  w_skid_valid;
    logic [1:0]            w_skid_cnt;
    logic [DATA_WIDTH-1:0] w_skid_head;

    logic                  w_pop;
    logic [2:0]            w_skid_occ;
    logic                  w_rd_want;
    logic                  w_wr_ok;
    logic                  w_in_ready;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic                  w_conflict;
    logic [ADDR_WIDTH:0]   w_used_nxt;
    logic [1:0]            w_skid_nxt;
    logic [ADDR_WIDTH+1:0] w_level_nxt;

    // RAM reset asserts with rst_n and releases one clock after rst_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_rst <= 1'b1;
        end else begin
            r_ram_rst <= 1'b0;
        end
    end

    // Request generation and single-port arbitration
    always_comb begin
        w_pop      = w_skid_valid && out_ready;
        // Skid slots already committed: stored words plus the read in flight,
        // minus the one leaving this cycle. A new read needs a free slot.
        w_skid_occ = {1'b0, w_skid_cnt} + {2'b00, r_rd_inflight} - {2'b00, w_pop};
        w_rd_want  = (r_used != '0) && (w_skid_occ < 3'd2);
        w_wr_ok    = (r_used != LP_FULL) && !r_ram_rst;
        w_in_ready = w_wr_ok && (!w_rd_want || (r_prio == PRIO_WR));
        w_wr_fire  = in_valid && w_in_ready;
        w_rd_fire  = w_rd_want && !w_wr_fire;
        w_conflict = in_valid && w_wr_ok && w_rd_want;
    end

    // Next-state occupancy, used to keep level equal to the current contents
    always_comb begin
        w_used_nxt = r_used;
        if (w_wr_fire) begin
            w_used_nxt = r_used + (ADDR_WIDTH+1)'(1);
        end else if (w_rd_fire) begin
            w_used_nxt = r_used - (ADDR_WIDTH+1)'(1);
        end
        w_skid_nxt  = w_skid_cnt + {1'b0, r_rd_inflight} - {1'b0, w_pop};
        w_level_nxt = (ADDR_WIDTH+2)'(w_used_nxt)
                    + (ADDR_WIDTH+2)'(w_rd_fire)
                    + (ADDR_WIDTH+2)'(w_skid_nxt);
    end

    // Ring pointers, RAM occupancy, read tracking, priority and level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_used        <= '0;
            r_rd_inflight <= 1'b0;
            r_prio        <= PRIO_WR;
            r_level       <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            if (w_conflict) begin
                r_prio <= prio_flip(r_prio);
            end
            r_used        <= w_used_nxt;
            r_rd_inflight <= w_rd_fire;
            r_level       <= w_level_nxt;
        end
    end

    bram_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_rd_inflight),
        .i_pop   (w_pop),
        .i_din   (ram_rdata),
        .o_valid (w_skid_valid),
        .o_cnt   (w_skid_cnt),
        .o_head  (w_skid_head)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_skid_valid;
    assign out_data  = w_skid_head;
    assign level     = r_level;
    assign ram_rst   = r_ram_rst;
    assign ram_wea   = w_wr_fire;
    assign ram_addr  = w_wr_fire ? r_wr_ptr : r_rd_ptr;
    assign ram_wdata = in_data;

endmodule
